// File: rtl/shift_issue_stage.sv
// Issue stage ahead of the combinational shifter: a 2-entry FIFO with a valid/ready handshake.
// Operand B is split at write time into a shift amount and an oversize flag; opcode 11 is dropped.
module shift_issue_stage #(
  parameter int N  = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_op,
  output logic [N-1:0]  out_a,
  output logic [SW-1:0] out_shamt,
  output logic          out_oversize,
  output logic [1:0]    occupancy,
  output logic          err_illegal
);

  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // Storage is deliberately not reset; it is only observed while counted valid.
  logic [1:0]    op_mem    [2];
  logic [N-1:0]  a_mem     [2];
  logic [SW-1:0] shamt_mem [2];
  logic          ovs_mem   [2];

  logic [1:0] count_reg;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic       err_reg;

  logic accept;
  logic enq;
  logic deq;

  assign in_ready  = rstb && (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign accept    = in_valid && in_ready;
  assign enq       = accept && (in_op != OP_ILLEGAL);
  assign deq       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (enq) begin
      op_mem[wr_ptr_reg]    <= in_op;
      a_mem[wr_ptr_reg]     <= in_a;
      shamt_mem[wr_ptr_reg] <= in_b[SW-1:0];
      ovs_mem[wr_ptr_reg]   <= |in_b[N-1:SW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      if (enq) wr_ptr_reg <= ~wr_ptr_reg;
      if (deq) rd_ptr_reg <= ~rd_ptr_reg;
      if (enq && !deq)      count_reg <= count_reg + 2'd1;
      else if (!enq && deq) count_reg <= count_reg - 2'd1;
      if (accept && (in_op == OP_ILLEGAL)) err_reg <= 1'b1;
    end
  end

  assign out_op       = op_mem[rd_ptr_reg];
  assign out_a        = a_mem[rd_ptr_reg];
  assign out_shamt    = shamt_mem[rd_ptr_reg];
  assign out_oversize = ovs_mem[rd_ptr_reg];
  assign occupancy    = count_reg;
  assign err_illegal  = err_reg;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: a per-cycle vector table plus streaming and reset sequences.
module tb_shift_issue_stage;

  localparam int N  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rstb;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_op;
  logic [N-1:0]  out_a;
  logic [SW-1:0] out_shamt;
  logic          out_oversize;
  logic [1:0]    occupancy;
  logic          err_illegal;

  int total  = 0;
  int passed = 0;

  shift_issue_stage #(.N(N), .SW(SW)) dut (
    .clk(clk), .rstb(rstb),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_a(out_a),
    .out_shamt(out_shamt), .out_oversize(out_oversize),
    .occupancy(occupancy), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [1:0]    op;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          ordy;
    logic          e_irdy;
    logic          e_ov;
    logic [1:0]    e_op;
    logic [N-1:0]  e_a;
    logic [SW-1:0] e_sh;
    logic          e_ovs;
    logic [1:0]    e_occ;
    logic          e_err;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic v, logic [1:0] op, logic [N-1:0] a, logic [N-1:0] b,
                              logic ordy, logic e_irdy, logic e_ov, logic [1:0] e_op,
                              logic [N-1:0] e_a, logic [SW-1:0] e_sh, logic e_ovs,
                              logic [1:0] e_occ, logic e_err);
    vec_t r;
    r.v = v; r.op = op; r.a = a; r.b = b; r.ordy = ordy;
    r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_op = e_op; r.e_a = e_a;
    r.e_sh = e_sh; r.e_ovs = e_ovs; r.e_occ = e_occ; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic ordy);
    in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy;
  endtask

  initial begin
    // Single request, oversize cases, backpressure A/B/C, illegal op between two SRAs.
    tbl[0]  = mk(1, 2'b01, 32'hF0000000, 32'd4,  1, 1, 0, 2'b00, 32'h0, 5'd0, 0, 2'd0, 0);
    tbl[1]  = mk(0, 2'b00, 32'h0, 32'h0,         1, 1, 1, 2'b01, 32'hF0000000, 5'd4, 0, 2'd1, 0);
    tbl[2]  = mk(1, 2'b00, 32'h1, 32'h20,        1, 1, 0, 2'b00, 32'h0, 5'd0, 0, 2'd0, 0);
    tbl[3]  = mk(1, 2'b10, 32'h80000000, 32'h1F, 1, 1, 1, 2'b00, 32'h1, 5'd0, 1, 2'd1, 0);
    tbl[4]  = mk(0, 2'b00, 32'h0, 32'h0,         1, 1, 1, 2'b10, 32'h80000000, 5'd31, 0, 2'd1, 0);
    tbl[5]  = mk(1, 2'b00, 32'hA, 32'd1,         0, 1, 0, 2'b00, 32'h0, 5'd0, 0, 2'd0, 0);
    tbl[6]  = mk(1, 2'b01, 32'hB, 32'd2,         0, 1, 1, 2'b00, 32'hA, 5'd1, 0, 2'd1, 0);
    tbl[7]  = mk(1, 2'b10, 32'hC, 32'd3,         0, 0, 1, 2'b00, 32'hA, 5'd1, 0, 2'd2, 0);
    tbl[8]  = mk(1, 2'b10, 32'hC, 32'd3,         1, 0, 1, 2'b00, 32'hA, 5'd1, 0, 2'd2, 0);
    tbl[9]  = mk(1, 2'b10, 32'hC, 32'd3,         1, 1, 1, 2'b01, 32'hB, 5'd2, 0, 2'd1, 0);
    tbl[10] = mk(0, 2'b00, 32'h0, 32'h0,         1, 1, 1, 2'b10, 32'hC, 5'd3, 0, 2'd1, 0);
    tbl[11] = mk(0, 2'b00, 32'h0, 32'h0,         1, 1, 0, 2'b00, 32'h0, 5'd0, 0, 2'd0, 0);
    tbl[12] = mk(1, 2'b10, 32'h80000001, 32'h21, 0, 1, 0, 2'b00, 32'h0, 5'd0, 0, 2'd0, 0);
    tbl[13] = mk(1, 2'b11, 32'hDEAD, 32'h0,      0, 1, 1, 2'b10, 32'h80000001, 5'd1, 1, 2'd1, 0);
    tbl[14] = mk(1, 2'b10, 32'h40, 32'h2,        1, 1, 1, 2'b10, 32'h80000001, 5'd1, 1, 2'd1, 1);
    tbl[15] = mk(1, 2'b11, 32'h0, 32'h0,         1, 1, 1, 2'b10, 32'h40, 5'd2, 0, 2'd1, 1);
    tbl[16] = mk(0, 2'b00, 32'h0, 32'h0,         1, 1, 0, 2'b00, 32'h0, 5'd0, 0, 2'd0, 1);

    rstb = 1'b0;
    drive(0, 2'b00, '0, '0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_err", err_illegal, 0);
    rstb = 1'b1; #1;
    chk("post_rst_in_ready", in_ready, 1);
    $display("reset: in_ready=%0b out_valid=%0b occ=%0d", in_ready, out_valid, occupancy);

    for (int i = 0; i < 17; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_irdy);
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("v%0d_occupancy", i), occupancy, tbl[i].e_occ);
      chk($sformatf("v%0d_err", i), err_illegal, tbl[i].e_err);
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d_out_op", i), out_op, tbl[i].e_op);
        chk($sformatf("v%0d_out_a", i), out_a, tbl[i].e_a);
        chk($sformatf("v%0d_out_shamt", i), out_shamt, tbl[i].e_sh);
        chk($sformatf("v%0d_out_oversize", i), out_oversize, tbl[i].e_ovs);
      end
      $display("vec %0d: v=%0b op=%0d a=%h b=%h ordy=%0b -> irdy=%0b ov=%0b a=%h occ=%0d err=%0b",
               i, tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ordy,
               in_ready, out_valid, out_a, occupancy, err_illegal);
    end

    // Streaming across pointer wrap: every request leaves one cycle after acceptance.
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i < 10) drive(1, 2'b01, 32'h100 + i, i, 1);
      else        drive(0, 2'b00, '0, '0, 1);
      #1;
      if (i == 0) begin
        chk("stream0_out_valid", out_valid, 0);
      end else begin
        chk($sformatf("stream%0d_out_valid", i), out_valid, 1);
        chk($sformatf("stream%0d_out_a", i), out_a, 32'h100 + i - 1);
        chk($sformatf("stream%0d_out_shamt", i), out_shamt, i - 1);
        chk($sformatf("stream%0d_occupancy", i), occupancy, 1);
        chk($sformatf("stream%0d_in_ready", i), in_ready, 1);
      end
      $display("stream %0d: ov=%0b a=%h occ=%0d", i, out_valid, out_a, occupancy);
    end
    @(negedge clk); drive(0, 2'b00, '0, '0, 1); #1;
    chk("stream_drained", occupancy, 0);

    // Reset while full: everything discarded, err cleared, nothing stale afterwards.
    @(negedge clk); drive(1, 2'b00, 32'h55, 32'd7, 0);
    @(negedge clk); drive(1, 2'b11, 32'h0, 32'h0, 0);
    @(negedge clk); drive(1, 2'b00, 32'h66, 32'd8, 0);
    @(negedge clk); drive(0, 2'b00, '0, '0, 0); #1;
    chk("midrst_full", occupancy, 2);
    chk("midrst_err_set", err_illegal, 1);
    rstb = 1'b0; #1;
    chk("midrst_in_ready_low", in_ready, 0);
    @(negedge clk); #1;
    chk("midrst_occupancy", occupancy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err", err_illegal, 0);
    rstb = 1'b1; out_ready = 1'b1; #1;
    chk("midrst_in_ready_high", in_ready, 1);
    $display("midreset: occ=%0d ov=%0b err=%0b irdy=%0b", occupancy, out_valid, err_illegal, in_ready);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("post_midrst%0d_out_valid", i), out_valid, 0);
      chk($sformatf("post_midrst%0d_occupancy", i), occupancy, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
